// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtraction controller: FSM encodings
// and the default operand width.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : sub_pkg

// File: rtl/serial_sub_ctrl_fs.sv
// Single-bit full subtractor cell: diff = a - b - b_in, with borrow out.
module FS (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  // Borrow when the subtrahend side (b + b_in) exceeds a.
  assign b_out = (~a & (b | b_in)) | (b & b_in);

endmodule : FS

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - b_in controller: one FS step per clock, LSB first, with
// a start/busy/done handshake and a result register held between operations.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic [1:0]       state
);

  // Handshake: start is a request sampled only in IDLE; the edge that sees it
  // accepts a/b/b_in. busy is high for exactly WIDTH cycles afterwards, then
  // done pulses for one cycle with diff/b_out already valid. Requests seen
  // while busy or done are dropped, not queued.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_next;
  logic [WIDTH-1:0] sa, sb, wd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             accept, step, finish;
  logic             busy_next, done_next;
  logic             fs_diff, fs_borrow;
  logic [WIDTH-1:0] wd_shift;

  FS u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .b_in (br),
    .diff (fs_diff),
    .b_out(fs_borrow)
  );

  // Shift-right with the fresh bit entering at the MSB; written without a
  // part-select so WIDTH=1 needs no special case.
  assign wd_shift = (wd >> 1) | (WIDTH'(fs_diff) << (WIDTH - 1));

  always_comb begin
    state_next = state_q;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    busy_next = (state_next == ST_RUN);
    done_next = (state_next == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      wd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      br  <= b_in;
      cnt <= '0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      wd  <= wd_shift;
      br  <= fs_borrow;
      cnt <= cnt + 1'b1;
      if (finish) begin
        diff  <= wd_shift;
        b_out <= fs_borrow;
      end
    end
  end

  assign state = state_q;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: an 8-bit instance for the main
// scenarios and a 1-bit instance checked against the full-subtractor table.
module tb_serial_sub_ctrl;
  import sub_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit instance
  logic         start;
  logic [W-1:0] a, b;
  logic         b_in;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         b_out;
  logic [1:0]   state;

  // 1-bit instance
  logic       start1, a1, b1, bi1;
  logic       busy1, done1, diff1, bo1;
  logic [1:0] state1;

  serial_sub_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out), .state(state)
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .b_in(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .b_out(bo1), .state(state1)
  );

  logic [W:0] exp_q[$];
  logic [1:0] exp1_q[$];
  logic [W:0] last_res;
  int errors = 0;
  int checks = 0;

  function automatic logic [W:0] sub_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bi);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  endfunction

  task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    @(negedge clk);
    a = x; b = y; b_in = bi; start = 1'b1;
    exp_q.push_back(sub_model(x, y, bi));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
  endtask

  // Waits on negedges from the first one after the accept edge.
  task automatic wait_done(output int lat, output int busy_n, output bit to);
    lat = 0; busy_n = 0; to = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_n++;
      lat++;
      if (lat > 40) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, diff, b_out, state} !== {2'b00, {W{1'b0}}, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b diff=%h b_out=%b state=%0d required all 0",
               busy, done, diff, b_out, state);
    end
    checks++;
    if ({busy1, done1, diff1, bo1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs_w1: got %b required 0000", {busy1, done1, diff1, bo1});
    end
    rst_n = 1'b1;
    last_res = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, busy_n;
    bit to;
    logic [W:0] e;
    send_op(8'h5A, 8'h23, 1'b0);
    wait_done(lat, busy_n, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout: no done within 40 cycles");
    end
    checks++;
    if (lat !== W || busy_n !== W) begin
      errors++;
      $display("FAIL basic_latency: lat=%0d busy_cycles=%0d required %0d/%0d", lat, busy_n, W, W);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_with_done: busy=%b required 0", busy);
    end
    checks++;
    if ({b_out, diff} !== e || e !== 9'h037) begin
      errors++;
      $display("FAIL basic_result: got %h required %h", {b_out, diff}, e);
    end
    last_res = e;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || {b_out, diff} !== last_res || state !== 2'd0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b res=%h state=%0d required 0/%h/0",
               done, {b_out, diff}, state, last_res);
    end
  endtask

  task automatic test_borrow();
    int lat, busy_n;
    bit to;
    logic [W:0] e;
    send_op(8'h00, 8'h01, 1'b0);
    wait_done(lat, busy_n, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {b_out, diff} !== e) begin
      errors++;
      $display("FAIL borrow_underflow: got %h required %h timeout=%b", {b_out, diff}, e, to);
    end
    last_res = e;
    send_op(8'h10, 8'h10, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if ({b_out, diff} !== last_res || busy !== 1'b1) begin
      errors++;
      $display("FAIL borrow_hold: got %h busy=%b required %h busy=1", {b_out, diff}, busy, last_res);
    end
    wait_done(lat, busy_n, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {b_out, diff} !== e || e !== 9'h1FF) begin
      errors++;
      $display("FAIL borrow_in: got %h required %h timeout=%b", {b_out, diff}, e, to);
    end
    last_res = e;
  endtask

  task automatic test_back_to_back();
    int phase;
    int accepts;
    logic [W:0] e;
    phase = -1;
    accepts = 0;
    @(negedge clk);
    for (int i = 0; i < 3 * (W + 2); i++) begin
      if (phase >= 0) begin
        checks++;
        if (done !== (phase == W) || busy !== (phase < W)) begin
          errors++;
          $display("FAIL b2b_handshake: phase=%0d done=%b busy=%b", phase, done, busy);
        end
        if (done && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if ({b_out, diff} !== e) begin
            errors++;
            $display("FAIL b2b_result: got %h required %h", {b_out, diff}, e);
          end
          last_res = e;
        end else if (phase < W) begin
          checks++;
          if ({b_out, diff} !== last_res) begin
            errors++;
            $display("FAIL b2b_hold: got %h required %h", {b_out, diff}, last_res);
          end
        end
      end
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      b_in = 1'($urandom_range(0, 1));
      start = 1'b1;
      if (phase < 0 || phase == W + 1) begin
        exp_q.push_back(sub_model(a, b, b_in));
        accepts++;
        phase = 0;
      end else begin
        phase++;
      end
      @(negedge clk);
      if (phase == 0) phase = 0;
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() != 0 || accepts != 3) begin
      errors++;
      $display("FAIL b2b_drain: pending=%0d accepts=%0d required 0/3", exp_q.size(), accepts);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, busy_n;
    bit to;
    bit saw_done;
    logic [W:0] e;
    send_op(8'hC3, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, b_out, state} !== {2'b00, {W{1'b0}}, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b diff=%h b_out=%b state=%0d required 0",
               busy, done, diff, b_out, state);
    end
    exp_q.delete();
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid_no_done: done=1 observed required 0");
    end
    last_res = '0;
    send_op(8'hFF, 8'h0F, 1'b0);
    wait_done(lat, busy_n, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {b_out, diff} !== e || e !== 9'h0F0) begin
      errors++;
      $display("FAIL reset_mid_recover: got %h required %h timeout=%b", {b_out, diff}, e, to);
    end
    last_res = e;
  endtask

  task automatic test_width1();
    logic [7:0] diff_tab;
    logic [7:0] borrow_tab;
    logic [2:0] idx;
    logic [1:0] e;
    int lat;
    diff_tab   = 8'b1001_0110;
    borrow_tab = 8'b1000_1110;
    for (int k = 0; k < 9; k++) begin
      idx = (k == 0) ? 3'd1 : 3'(k - 1);
      @(negedge clk);
      {a1, b1, bi1} = idx;
      start1 = 1'b1;
      exp1_q.push_back({borrow_tab[idx], diff_tab[idx]});
      @(posedge clk);
      #1;
      start1 = 1'b0;
      {a1, b1, bi1} = 3'($urandom);
      lat = 0;
      forever begin
        @(negedge clk);
        if (done1 || lat > 10) break;
        lat++;
      end
      e = exp1_q.pop_front();
      checks++;
      if (!done1 || lat != 1 || {bo1, diff1} !== e) begin
        errors++;
        $display("FAIL w1_case%0d: done=%b lat=%0d got %b required lat=1 %b",
                 idx, done1, lat, {bo1, diff1}, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_sub_ctrl
